// File: rtl/matmul_sched_if.sv
// Request/grant bundle between the requester ports and the shared-multiplier scheduler.
interface matmul_sched_if #(
   parameter int R = 4
);
   logic [R-1:0]         req;
   logic [R-1:0]         grant;
   logic [$clog2(R)-1:0] grant_idx;
   logic                 busy;
   logic                 cap_en;
   logic [R-1:0]         done;
   logic [15:0]          op_cnt;

   modport master (
      output req,
      input  grant, grant_idx, busy, cap_en, done, op_cnt
   );

   modport slave (
      input  req,
      output grant, grant_idx, busy, cap_en, done, op_cnt
   );
endinterface

// File: rtl/matmul_sched.sv
// Round-robin scheduler sharing one fixed-latency matrix multiplier among R requesters.
// Grant is held for LAT+1 cycles; cap_en/done pulse in the final one.
module matmul_sched #(
   parameter int R   = 4,
   parameter int LAT = 3
) (
   input logic           clk,
   input logic           rst,
   matmul_sched_if.slave bus
);
   localparam int IW = $clog2(R);
   localparam int CW = $clog2(LAT + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [IW-1:0]   ptr, ptr_nx, grant_idx_q, idx_nx;
   logic [IW-1:0]   next_ptr, start, win_idx, k;
   logic [R-1:0]    grant_q, grant_nx, done_d, cand;
   logic            busy_q, busy_nx, cap, win;
   logic [15:0]     op_cnt_q, op_cnt_nx;

   assign cap      = (state == RUN) && (cnt == '0);
   assign next_ptr = (32'(grant_idx_q) == R - 1) ? '0 : grant_idx_q + IW'(1);

   always_comb begin
      done_d = '0;
      if (cap) done_d[grant_idx_q] = 1'b1;
   end

   // In the done cycle arbitration already starts after the served requester,
   // and its own bit is masked so it cannot win back-to-back.
   assign cand  = bus.req & ~done_d;
   assign start = cap ? next_ptr : ptr;

   always_comb begin
      win     = 1'b0;
      win_idx = '0;
      k       = '0;
      for (int unsigned i = 0; i < R; i++) begin
         k = IW'((32'(start) + i) % R);
         if (!win && cand[k]) begin
            win     = 1'b1;
            win_idx = k;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      grant_nx  = grant_q;
      idx_nx    = grant_idx_q;
      busy_nx   = busy_q;
      ptr_nx    = ptr;
      op_cnt_nx = op_cnt_q;
      unique case (state)
         IDLE: begin
            if (win) begin
               state_nx = RUN;
               cnt_nx   = CW'(LAT);
               grant_nx = R'(1) << win_idx;
               idx_nx   = win_idx;
               busy_nx  = 1'b1;
            end
         end
         RUN: begin
            if (!cap) begin
               cnt_nx = cnt - CW'(1);
            end else begin
               ptr_nx    = next_ptr;
               op_cnt_nx = op_cnt_q + 16'd1;
               if (win) begin
                  cnt_nx   = CW'(LAT);
                  grant_nx = R'(1) << win_idx;
                  idx_nx   = win_idx;
               end else begin
                  state_nx = IDLE;
                  grant_nx = '0;
                  idx_nx   = '0;
                  busy_nx  = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         ptr         <= '0;
         grant_q     <= '0;
         grant_idx_q <= '0;
         busy_q      <= 1'b0;
         op_cnt_q    <= '0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         ptr         <= ptr_nx;
         grant_q     <= grant_nx;
         grant_idx_q <= idx_nx;
         busy_q      <= busy_nx;
         op_cnt_q    <= op_cnt_nx;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.grant_idx = grant_idx_q;
   assign bus.busy      = busy_q;
   assign bus.cap_en    = cap;
   assign bus.done      = done_d;
   assign bus.op_cnt    = op_cnt_q;
endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench for matmul_sched: directed scenarios plus randomized
// request sets checked against a transaction-level round-robin model.
module tb_matmul_sched;
   localparam int R   = 4;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   exp_ops  = 0;

   matmul_sched_if #(.R(R)) bus ();
   matmul_sched #(.R(R), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Stand-in 2x2 multiplier: operand mux by grant_idx, then LAT register stages.
   int opa [R][4];
   int opb [R][4];
   int s1a [4];
   int s1b [4];
   int s2  [4];
   int c_out [4];
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         s1a[i]   <= opa[bus.grant_idx][i];
         s1b[i]   <= opb[bus.grant_idx][i];
         c_out[i] <= s2[i];
      end
      s2[0] <= s1a[0] * s1b[0] + s1a[1] * s1b[2];
      s2[1] <= s1a[0] * s1b[1] + s1a[1] * s1b[3];
      s2[2] <= s1a[2] * s1b[0] + s1a[3] * s1b[2];
      s2[3] <= s1a[2] * s1b[1] + s1a[3] * s1b[3];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cap(input string name);
      int k = 0;
      while (bus.cap_en !== 1'b1 && k < 40) begin
         tick();
         k++;
      end
      checks++;
      if (bus.cap_en !== 1'b1) begin failures++; $display("FAIL %s_timeout cap_en=%b exp=1", name, bus.cap_en); end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.req = '0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.req = '0;
      tick();
      checks++; if (bus.grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
      checks++; if (bus.grant_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.grant_idx); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.cap_en !== 1'b0) begin failures++; $display("FAIL reset_cap got=%b exp=0", bus.cap_en); end
      checks++; if (bus.done !== 4'b0) begin failures++; $display("FAIL reset_done got=%b exp=0000", bus.done); end
      checks++; if (bus.op_cnt !== 16'd0) begin failures++; $display("FAIL reset_opcnt got=%0d exp=0", bus.op_cnt); end
      rst = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b exp=0", bus.busy); end
      exp_ops = 0;
   endtask

   task automatic test_single();
      int exp_c [4] = '{19, 22, 43, 50};
      bus.req = 4'b0001;
      for (int k = 1; k <= LAT + 1; k++) begin
         tick();
         checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL single_grant cyc=%0d got=%b exp=0001", k, bus.grant); end
         if (k <= LAT) begin
            checks++; if (bus.cap_en !== 1'b0) begin failures++; $display("FAIL single_early_cap cyc=%0d got=%b exp=0", k, bus.cap_en); end
         end
      end
      checks++; if (bus.cap_en !== 1'b1) begin failures++; $display("FAIL single_cap got=%b exp=1", bus.cap_en); end
      checks++; if (bus.done !== 4'b0001) begin failures++; $display("FAIL single_done got=%b exp=0001", bus.done); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (c_out[i] !== exp_c[i]) begin failures++; $display("FAIL single_c%0d got=%0d exp=%0d", i, c_out[i], exp_c[i]); end
      end
      bus.req = '0;
      tick();
      exp_ops++;
      checks++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0) begin failures++; $display("FAIL single_idle busy=%b grant=%b exp=0/0000", bus.busy, bus.grant); end
      checks++; if (bus.op_cnt !== 16'(exp_ops)) begin failures++; $display("FAIL single_opcnt got=%0d exp=%0d", bus.op_cnt, exp_ops); end
   endtask

   task automatic test_back_to_back();
      logic [R-1:0] done_prev, low_prev, req_v, exp_g;
      int k;
      do_reset();
      exp_ops = 0;
      done_prev = '0;
      low_prev  = '0;
      bus.req   = 4'b1111;
      for (int c = 1; c <= 21; c++) begin
         tick();
         if (c <= 20) begin
            exp_g = 4'(1 << (((c - 1) / 4) % 4));
            checks++; if (bus.grant !== exp_g) begin failures++; $display("FAIL b2b_grant cyc=%0d got=%b exp=%b", c, bus.grant, exp_g); end
         end else begin
            checks++; if (bus.op_cnt !== 16'd5) begin failures++; $display("FAIL b2b_opcnt got=%0d exp=5", bus.op_cnt); end
         end
         req_v     = (bus.req | low_prev) & ~done_prev;
         low_prev  = done_prev;
         done_prev = bus.done;
         bus.req   = req_v;
      end
      bus.req = '0;
      k = 0;
      while (bus.busy !== 1'b0 && k < 20) begin tick(); k++; end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_drain busy=%b exp=0", bus.busy); end
      exp_ops = 6;
   endtask

   task automatic test_fairness_wrap();
      bus.req = 4'b0100;
      tick();
      wait_cap("wrap_prep");
      bus.req = '0;
      tick();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wrap_prep_idle busy=%b exp=0", bus.busy); end
      bus.req = 4'b0101;
      tick();
      checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL wrap_first got=%b exp=0001", bus.grant); end
      wait_cap("wrap_first");
      bus.req = 4'b0100;
      tick();
      checks++; if (bus.grant !== 4'b0100) begin failures++; $display("FAIL wrap_second got=%b exp=0100", bus.grant); end
      wait_cap("wrap_second");
      bus.req = '0;
      tick();
      exp_ops += 3;
   endtask

   task automatic test_withdraw();
      bus.req = 4'b0100;
      tick();
      tick();
      bus.req = '0;
      tick();
      tick();
      checks++; if (bus.cap_en !== 1'b1 || bus.done !== 4'b0100) begin failures++; $display("FAIL withdraw_done cap=%b done=%b exp=1/0100", bus.cap_en, bus.done); end
      tick();
      exp_ops++;
      checks++; if (bus.op_cnt !== 16'(exp_ops)) begin failures++; $display("FAIL withdraw_opcnt got=%0d exp=%0d", bus.op_cnt, exp_ops); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL withdraw_idle busy=%b exp=0", bus.busy); end
   endtask

   task automatic test_self_mask();
      bus.req = 4'b0010;
      tick();
      wait_cap("mask_first");
      tick();
      checks++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0) begin failures++; $display("FAIL mask_gap busy=%b grant=%b exp=0/0000", bus.busy, bus.grant); end
      tick();
      checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL mask_regrant got=%b exp=0010", bus.grant); end
      wait_cap("mask_second");
      bus.req = '0;
      tick();
      exp_ops += 2;
   endtask

   task automatic test_reset_mid();
      bus.req = 4'b1000;
      tick();
      tick();
      tick();
      checks++; if (bus.grant !== 4'b1000) begin failures++; $display("FAIL rmid_grant got=%b exp=1000", bus.grant); end
      rst = 1'b0;
      #1;
      checks++; if (bus.grant !== 4'b0 || bus.grant_idx !== 2'd0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_clear grant=%b idx=%0d busy=%b exp=0", bus.grant, bus.grant_idx, bus.busy); end
      checks++; if (bus.cap_en !== 1'b0 || bus.done !== 4'b0 || bus.op_cnt !== 16'd0) begin failures++; $display("FAIL rmid_clear2 cap=%b done=%b op=%0d exp=0", bus.cap_en, bus.done, bus.op_cnt); end
      bus.req = 4'b1001;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (bus.cap_en !== 1'b0) begin failures++; $display("FAIL rmid_nocap cyc=%0d got=%b exp=0", k, bus.cap_en); end
      end
      rst = 1'b1;
      tick();
      checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL rmid_restart got=%b exp=0001", bus.grant); end
      wait_cap("rmid_r0");
      bus.req = 4'b1000;
      tick();
      wait_cap("rmid_r3");
      bus.req = '0;
      tick();
      exp_ops = 2;
      checks++; if (bus.op_cnt !== 16'(exp_ops)) begin failures++; $display("FAIL rmid_opcnt got=%0d exp=%0d", bus.op_cnt, exp_ops); end
   endtask

   task automatic test_random_rr();
      logic [R-1:0] mask, pend;
      logic [1:0]   pos;
      int ptr_m, n, served, exp_i;
      do_reset();
      ptr_m   = 0;
      exp_ops = 0;
      for (int rnd = 0; rnd < 12; rnd++) begin
         mask    = R'($urandom_range(1, (1 << R) - 1));
         bus.req = mask;
         pend    = mask;
         n       = $countones(mask);
         served  = 0;
         for (int k = 1; k <= n * (LAT + 1) + 4 && served < n; k++) begin
            tick();
            if (bus.cap_en === 1'b1) begin
               exp_i = -1;
               for (int j = 0; j < R; j++) begin
                  pos = 2'((ptr_m + j) % R);
                  if (exp_i < 0 && pend[pos]) exp_i = int'(pos);
               end
               checks++; if (bus.done !== R'(1 << exp_i)) begin failures++; $display("FAIL rr_order rnd=%0d got=%b exp=%b", rnd, bus.done, R'(1 << exp_i)); end
               checks++; if (k != (served + 1) * (LAT + 1)) begin failures++; $display("FAIL rr_timing rnd=%0d cyc=%0d exp=%0d", rnd, k, (served + 1) * (LAT + 1)); end
               pend    = pend & ~R'(1 << exp_i);
               ptr_m   = (exp_i + 1) % R;
               served++;
               bus.req = bus.req & ~bus.done;
            end
         end
         checks++; if (served != n) begin failures++; $display("FAIL rr_count rnd=%0d got=%0d exp=%0d", rnd, served, n); end
         exp_ops += n;
         bus.req = '0;
         tick();
         checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rr_idle rnd=%0d busy=%b exp=0", rnd, bus.busy); end
      end
      checks++; if (bus.op_cnt !== 16'(exp_ops)) begin failures++; $display("FAIL rr_opcnt got=%0d exp=%0d", bus.op_cnt, exp_ops); end
   endtask

   task automatic test_opcnt_wrap();
      force dut.op_cnt_q = 16'hFFFF;
      tick();
      tick();
      release dut.op_cnt_q;
      #1;
      checks++; if (bus.op_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%0d exp=65535", bus.op_cnt); end
      bus.req = 4'b0001;
      tick();
      wait_cap("opcnt_wrap");
      bus.req = '0;
      tick();
      checks++; if (bus.op_cnt !== 16'd0) begin failures++; $display("FAIL opcnt_wrap got=%0d exp=0", bus.op_cnt); end
   endtask

   initial begin
      opa[0] = '{1, 2, 3, 4};
      opb[0] = '{5, 6, 7, 8};
      for (int r = 1; r < R; r++) begin
         opa[r] = '{0, 0, 0, 0};
         opb[r] = '{0, 0, 0, 0};
      end
      rst     = 1'b0;
      bus.req = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_fairness_wrap();
      test_withdraw();
      test_self_mask();
      test_reset_mid();
      test_random_rr();
      test_opcnt_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time=%0t limit=500000", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
